// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types for the multi-channel pinmux timer (timer_mc / timer_chan).
//   clksel_e : per-channel tick source encoding (cfg_clksel field)
//   mode_e   : periodic / one-shot reload behaviour (cfg_mode bit)
//   state_e  : per-channel FSM state
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        CLK_1US  = 2'b00,
        CLK_1MS  = 2'b01,
        CLK_1S   = 2'b10,
        CLK_MCLK = 2'b11
    } clksel_e;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/timer_chan.sv
// -----------------------------------------------------------------------------
// timer_chan
// One down-counting timer channel: tick source mux, IDLE/RUN/DONE FSM,
// WIDTH-bit counter with reload, sticky expiry flag with write-1-clear.
// Ports:
//   mclk, reset_n            clock, async active-low reset
//   pulse_1us/1ms/1s         single-cycle tick strobes
//   chain_tick, chain_sel    expiry of the previous channel and its select
//                            (chain_sel overrides clksel)
//   enb, update, compare     count enable, load strobe, reload value
//   clksel, mode             tick select, 0=periodic 1=one-shot
//   intr_clr                 write-1-clear for stat
//   count, active, stat      counter, RUN indication, sticky expiry flag
//   expiry                   same-cycle expiry event (feeds the next channel)
// -----------------------------------------------------------------------------
module timer_chan
    import timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic             pulse_1us,
    input  logic             pulse_1ms,
    input  logic             pulse_1s,
    input  logic             chain_tick,
    input  logic             chain_sel,
    input  logic             enb,
    input  logic             update,
    input  logic [WIDTH-1:0] compare,
    input  logic [1:0]       clksel,
    input  logic             mode,
    input  logic             intr_clr,
    output logic [WIDTH-1:0] count,
    output logic             active,
    output logic             stat,
    output logic             expiry
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_r;
    state_e           state_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             stat_r;
    logic             stat_nxt_s;
    logic             active_r;
    logic             tick_s;
    logic             expiry_s;

    // Tick source selection; a chained channel counts expiries of its predecessor.
    always_comb begin
        tick_s = 1'b0;
        if (chain_sel) begin
            tick_s = chain_tick;
        end else begin
            case (clksel_e'(clksel))
                CLK_1US:  tick_s = pulse_1us;
                CLK_1MS:  tick_s = pulse_1ms;
                CLK_1S:   tick_s = pulse_1s;
                CLK_MCLK: tick_s = 1'b1;
                default:  tick_s = 1'b0;
            endcase
        end
    end

    // Next-state, counter and expiry logic; a load strobe overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        expiry_s    = 1'b0;
        if (update) begin
            count_nxt_s = compare;
            state_nxt_s = enb ? ST_RUN : ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enb) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (tick_s && enb) begin
                        if (count_r != CNT_ZERO) begin
                            count_nxt_s = count_r - CNT_ONE;
                        end else begin
                            expiry_s = 1'b1;
                            if (mode_e'(mode) == MODE_ONESHOT) begin
                                state_nxt_s = ST_DONE;
                            end else begin
                                count_nxt_s = compare;
                            end
                        end
                    end else begin
                        count_nxt_s = count_r;
                    end
                end
                ST_DONE: begin
                    count_nxt_s = CNT_ZERO;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = CNT_ZERO;
                end
            endcase
        end
    end

    // Sticky expiry flag: a set in the same cycle as a clear wins.
    always_comb begin
        if (expiry_s) begin
            stat_nxt_s = 1'b1;
        end else if (intr_clr) begin
            stat_nxt_s = 1'b0;
        end else begin
            stat_nxt_s = stat_r;
        end
    end

    // Channel state registers.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            count_r  <= CNT_ZERO;
            stat_r   <= 1'b0;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            count_r  <= count_nxt_s;
            stat_r   <= stat_nxt_s;
            active_r <= (state_nxt_s == ST_RUN);
        end
    end

    assign count  = count_r;
    assign active = active_r;
    assign stat   = stat_r;
    assign expiry = expiry_s;

endmodule

// File: rtl/timer_mc.sv
// -----------------------------------------------------------------------------
// timer_mc
// NCH-channel down-counting timer for the pinmux block.
// Optional build macro: TIMER_CHAIN_EN adds cfg_chain, letting channel i>0
// tick on the expiry of channel i-1 to form cascaded counters.
// Ports:
//   mclk, reset_n                  clock, async active-low reset
//   pulse_1us/1ms/1s               tick strobes from the pulse generator
//   cfg_enb/update/compare/clksel/mode   per-channel configuration
//   cfg_chain (TIMER_CHAIN_EN)     per-channel cascade select (bit 0 ignored)
//   intr_mask, intr_clr            interrupt mask, write-1-clear
//   timer_count, timer_active      counters, RUN indications
//   intr_stat, timer_intr          sticky flags, masked interrupt OR
// -----------------------------------------------------------------------------
module timer_mc
    import timer_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 16
) (
    input  logic                 mclk,
    input  logic                 reset_n,
    input  logic                 pulse_1us,
    input  logic                 pulse_1ms,
    input  logic                 pulse_1s,
    input  logic [NCH-1:0]       cfg_enb,
    input  logic [NCH-1:0]       cfg_update,
    input  logic [NCH*WIDTH-1:0] cfg_compare,
    input  logic [NCH*2-1:0]     cfg_clksel,
    input  logic [NCH-1:0]       cfg_mode,
`ifdef TIMER_CHAIN_EN
    input  logic [NCH-1:0]       cfg_chain,
`endif
    input  logic [NCH-1:0]       intr_mask,
    input  logic [NCH-1:0]       intr_clr,
    output logic [NCH*WIDTH-1:0] timer_count,
    output logic [NCH-1:0]       timer_active,
    output logic [NCH-1:0]       intr_stat,
    output logic                 timer_intr
);

    logic [NCH-1:0] expiry_s;
    logic [NCH-1:0] chain_tick_s;
    logic [NCH-1:0] chain_sel_s;
    // Expiries with no consumer (last channel, or every channel without chaining).
    logic           expiry_unused_s;

    for (genvar i = 0; i < NCH; i++) begin : gen_chan
        if (i == 0) begin : g_head
            assign chain_tick_s[i] = 1'b0;
            assign chain_sel_s[i]  = 1'b0;
        end else begin : g_link
`ifdef TIMER_CHAIN_EN
            assign chain_tick_s[i] = expiry_s[i-1];
            assign chain_sel_s[i]  = cfg_chain[i];
`else
            assign chain_tick_s[i] = 1'b0;
            assign chain_sel_s[i]  = 1'b0;
`endif
        end

        timer_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .mclk       (mclk),
            .reset_n    (reset_n),
            .pulse_1us  (pulse_1us),
            .pulse_1ms  (pulse_1ms),
            .pulse_1s   (pulse_1s),
            .chain_tick (chain_tick_s[i]),
            .chain_sel  (chain_sel_s[i]),
            .enb        (cfg_enb[i]),
            .update     (cfg_update[i]),
            .compare    (cfg_compare[i*WIDTH +: WIDTH]),
            .clksel     (cfg_clksel[i*2 +: 2]),
            .mode       (cfg_mode[i]),
            .intr_clr   (intr_clr[i]),
            .count      (timer_count[i*WIDTH +: WIDTH]),
            .active     (timer_active[i]),
            .stat       (intr_stat[i]),
            .expiry     (expiry_s[i])
        );
    end

`ifdef TIMER_CHAIN_EN
    assign expiry_unused_s = ^{expiry_s, cfg_chain[0]};
`else
    assign expiry_unused_s = ^expiry_s;
`endif

    // Interrupt is a plain OR of registered flags, so no extra latency.
    assign timer_intr = |(intr_stat & intr_mask);

endmodule

// File: tb/tb_timer_mc.sv
// -----------------------------------------------------------------------------
// tb_timer_mc
// Self-checking bench for timer_mc (NCH=4, WIDTH=16). Scenario tasks push
// expected values into a scoreboard queue as stimulus is driven and pop them
// when the corresponding DUT cycle is sampled (#1 after the rising edge).
// -----------------------------------------------------------------------------
module tb_timer_mc;

    localparam int NCH   = 4;
    localparam int WIDTH = 16;

    logic                 mclk;
    logic                 reset_n;
    logic                 pulse_1us;
    logic                 pulse_1ms;
    logic                 pulse_1s;
    logic [NCH-1:0]       cfg_enb;
    logic [NCH-1:0]       cfg_update;
    logic [NCH*WIDTH-1:0] cfg_compare;
    logic [NCH*2-1:0]     cfg_clksel;
    logic [NCH-1:0]       cfg_mode;
`ifdef TIMER_CHAIN_EN
    logic [NCH-1:0]       cfg_chain;
`endif
    logic [NCH-1:0]       intr_mask;
    logic [NCH-1:0]       intr_clr;
    logic [NCH*WIDTH-1:0] timer_count;
    logic [NCH-1:0]       timer_active;
    logic [NCH-1:0]       intr_stat;
    logic                 timer_intr;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    timer_mc #(
        .NCH   (NCH),
        .WIDTH (WIDTH)
    ) dut (
        .mclk         (mclk),
        .reset_n      (reset_n),
        .pulse_1us    (pulse_1us),
        .pulse_1ms    (pulse_1ms),
        .pulse_1s     (pulse_1s),
        .cfg_enb      (cfg_enb),
        .cfg_update   (cfg_update),
        .cfg_compare  (cfg_compare),
        .cfg_clksel   (cfg_clksel),
        .cfg_mode     (cfg_mode),
`ifdef TIMER_CHAIN_EN
        .cfg_chain    (cfg_chain),
`endif
        .intr_mask    (intr_mask),
        .intr_clr     (intr_clr),
        .timer_count  (timer_count),
        .timer_active (timer_active),
        .intr_stat    (intr_stat),
        .timer_intr   (timer_intr)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] cnt(input int ch);
        return timer_count[ch*WIDTH +: WIDTH];
    endfunction

    task automatic push_exp(input string name, input logic [31:0] v);
        sb_item_t it;
        it.name = name;
        it.exp  = v;
        sb_q.push_back(it);
    endtask

    task automatic clear_inputs();
        pulse_1us   = 1'b0;
        pulse_1ms   = 1'b0;
        pulse_1s    = 1'b0;
        cfg_enb     = '0;
        cfg_update  = '0;
        cfg_compare = '0;
        cfg_clksel  = '0;
        cfg_mode    = '0;
`ifdef TIMER_CHAIN_EN
        cfg_chain   = '0;
`endif
        intr_mask   = '0;
        intr_clr    = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        #12;
        n_checks++;
        if (timer_count !== '0) begin
            n_errors++;
            $display("FAIL reset_count: got %h want 0", timer_count);
        end
        n_checks++;
        if (intr_stat !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_stat: got %b want 0000", intr_stat);
        end
        n_checks++;
        if (timer_active !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_active: got %b want 0000", timer_active);
        end
        n_checks++;
        if (timer_intr !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_intr: got %b want 0", timer_intr);
        end
        @(negedge mclk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_periodic();
        sb_item_t e;
        cfg_clksel[1:0]         = 2'b11;
        cfg_compare[0 +: WIDTH] = 16'd3;
        cfg_mode[0]             = 1'b0;
        cfg_enb[0]              = 1'b1;
        cfg_update[0]           = 1'b1;
        for (int k = 0; k < 9; k++) begin
            push_exp($sformatf("per_count_%0d", k), 32'(3 - (k % 4)));
            push_exp($sformatf("per_stat_%0d", k), 32'((k == 4 || k == 8) ? 1 : 0));
        end
        step();
        cfg_update[0] = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) step();
            e = sb_q.pop_front();
            n_checks++;
            if (cnt(0) !== e.exp[WIDTH-1:0]) begin
                n_errors++;
                $display("FAIL %s: got %0d want %0d", e.name, cnt(0), e.exp);
            end
            e = sb_q.pop_front();
            n_checks++;
            if (intr_stat[0] !== e.exp[0]) begin
                n_errors++;
                $display("FAIL %s: got %b want %b", e.name, intr_stat[0], e.exp[0]);
            end
            intr_clr[0] = (k == 4);
        end
        n_checks++;
        if (timer_active[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL per_active: got %b want 1", timer_active[0]);
        end
        // Freeze and clear: counter holds at reload value, flag drops.
        cfg_enb[0]  = 1'b0;
        intr_clr[0] = 1'b1;
        step();
        intr_clr[0] = 1'b0;
        n_checks++;
        if (intr_stat[0] !== 1'b0 || cnt(0) !== 16'd3) begin
            n_errors++;
            $display("FAIL per_freeze: got stat=%b count=%0d want stat=0 count=3",
                     intr_stat[0], cnt(0));
        end
    endtask

    task automatic test_oneshot();
        sb_item_t e;
        cfg_clksel[3:2]             = 2'b00;
        cfg_compare[WIDTH +: WIDTH] = 16'd2;
        cfg_mode[1]                 = 1'b1;
        cfg_enb[1]                  = 1'b1;
        cfg_update[1]               = 1'b1;
        step();
        cfg_update[1] = 1'b0;
        n_checks++;
        if (cnt(1) !== 16'd2 || timer_active[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL os_load: got count=%0d active=%b want 2/1", cnt(1), timer_active[1]);
        end
        for (int p = 1; p <= 5; p++) begin
            push_exp($sformatf("os_count_p%0d", p), (p == 1) ? 32'd1 : 32'd0);
            push_exp($sformatf("os_stat_p%0d", p), (p == 3) ? 32'd1 : 32'd0);
            push_exp($sformatf("os_active_p%0d", p), (p <= 2) ? 32'd1 : 32'd0);
            repeat (9) step();
            pulse_1us = 1'b1;
            step();
            pulse_1us = 1'b0;
            e = sb_q.pop_front();
            n_checks++;
            if (cnt(1) !== e.exp[WIDTH-1:0]) begin
                n_errors++;
                $display("FAIL %s: got %0d want %0d", e.name, cnt(1), e.exp);
            end
            e = sb_q.pop_front();
            n_checks++;
            if (intr_stat[1] !== e.exp[0]) begin
                n_errors++;
                $display("FAIL %s: got %b want %b", e.name, intr_stat[1], e.exp[0]);
            end
            e = sb_q.pop_front();
            n_checks++;
            if (timer_active[1] !== e.exp[0]) begin
                n_errors++;
                $display("FAIL %s: got %b want %b", e.name, timer_active[1], e.exp[0]);
            end
            if (p == 3) begin
                intr_clr[1] = 1'b1;
                step();
                intr_clr[1] = 1'b0;
            end
        end
    endtask

    task automatic test_clr_collision();
        cfg_clksel[5:4]                 = 2'b11;
        cfg_compare[2*WIDTH +: WIDTH]   = 16'd0;
        cfg_mode[2]                     = 1'b0;
        cfg_enb[2]                      = 1'b1;
        cfg_update[2]                   = 1'b1;
        intr_mask                       = 4'b0000;
        step();
        cfg_update[2] = 1'b0;
        n_checks++;
        if (cnt(2) !== 16'd0 || intr_stat[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL col_load: got count=%0d stat=%b want 0/0", cnt(2), intr_stat[2]);
        end
        step();
        n_checks++;
        if (intr_stat[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL col_first_expiry: got %b want 1", intr_stat[2]);
        end
        intr_clr[2] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (intr_stat[2] !== 1'b1) begin
                n_errors++;
                $display("FAIL col_set_wins_%0d: got %b want 1", k, intr_stat[2]);
            end
        end
        n_checks++;
        if (timer_intr !== 1'b0) begin
            n_errors++;
            $display("FAIL col_masked_intr: got %b want 0", timer_intr);
        end
        intr_mask[2] = 1'b1;
        #1;
        n_checks++;
        if (timer_intr !== 1'b1) begin
            n_errors++;
            $display("FAIL col_unmasked_intr: got %b want 1", timer_intr);
        end
        cfg_enb[2] = 1'b0;
        step();
        n_checks++;
        if (intr_stat[2] !== 1'b0 || timer_intr !== 1'b0) begin
            n_errors++;
            $display("FAIL col_clear: got stat=%b intr=%b want 0/0", intr_stat[2], timer_intr);
        end
        intr_clr[2]  = 1'b0;
        intr_mask[2] = 1'b0;
    endtask

    task automatic test_enb_freeze();
        sb_item_t e;
        cfg_clksel[7:6]               = 2'b11;
        cfg_compare[3*WIDTH +: WIDTH] = 16'd8;
        cfg_mode[3]                   = 1'b0;
        cfg_enb[3]                    = 1'b1;
        cfg_update[3]                 = 1'b1;
        for (int k = 0; k < 34; k++) begin
            // k 0..3 count down, 4..23 frozen, 24..25 resume,
            // 26 compare rewritten (no effect), 27 update, 28 continues.
            if (k == 1)  cfg_update[3] = 1'b0;
            if (k == 4)  cfg_enb[3] = 1'b0;
            if (k == 24) cfg_enb[3] = 1'b1;
            if (k == 26) cfg_compare[3*WIDTH +: WIDTH] = 16'd10;
            if (k == 27) cfg_update[3] = 1'b1;
            if (k == 28) cfg_update[3] = 1'b0;
            if (k >= 29) cfg_enb[3] = 1'b0;
            if (k < 4)        push_exp($sformatf("frz_count_%0d", k), 32'(8 - k));
            else if (k < 24)  push_exp($sformatf("frz_count_%0d", k), 32'd5);
            else if (k < 27)  push_exp($sformatf("frz_count_%0d", k), 32'(4 - (k - 24)));
            else if (k == 27) push_exp($sformatf("frz_count_%0d", k), 32'd10);
            else              push_exp($sformatf("frz_count_%0d", k), 32'd9);
            step();
            e = sb_q.pop_front();
            n_checks++;
            if (cnt(3) !== e.exp[WIDTH-1:0]) begin
                n_errors++;
                $display("FAIL %s: got %0d want %0d", e.name, cnt(3), e.exp);
            end
        end
        n_checks++;
        if (timer_active[3] !== 1'b1 || intr_stat[3] !== 1'b0) begin
            n_errors++;
            $display("FAIL frz_state: got active=%b stat=%b want 1/0", timer_active[3], intr_stat[3]);
        end
    endtask

    task automatic test_reset_midcount();
        cfg_enb[3] = 1'b1;
        step();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (timer_count !== '0 || timer_active !== 4'b0000) begin
            n_errors++;
            $display("FAIL midreset_count: got count=%h active=%b want 0/0", timer_count, timer_active);
        end
        n_checks++;
        if (intr_stat !== 4'b0000 || timer_intr !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_stat: got stat=%b intr=%b want 0/0", intr_stat, timer_intr);
        end
        clear_inputs();
        @(negedge mclk);
        reset_n = 1'b1;
        step();
    endtask

`ifdef TIMER_CHAIN_EN
    task automatic test_chain();
        sb_item_t e;
        cfg_clksel[1:0]             = 2'b11;
        cfg_compare[0 +: WIDTH]     = 16'd1;
        cfg_compare[WIDTH +: WIDTH] = 16'd2;
        cfg_mode[1:0]               = 2'b00;
        cfg_chain[1]                = 1'b1;
        cfg_enb[1:0]                = 2'b11;
        cfg_update[1:0]             = 2'b11;
        step();
        cfg_update[1:0] = 2'b00;
        n_checks++;
        if (cnt(0) !== 16'd1 || cnt(1) !== 16'd2) begin
            n_errors++;
            $display("FAIL chain_load: got %0d/%0d want 1/2", cnt(0), cnt(1));
        end
        for (int k = 1; k <= 18; k++) begin
            push_exp($sformatf("chain_stat_%0d", k), 32'((k % 6 == 0) ? 1 : 0));
            push_exp($sformatf("chain_count_%0d", k), 32'(2 - ((k / 2) % 3)));
            step();
            e = sb_q.pop_front();
            n_checks++;
            if (intr_stat[1] !== e.exp[0]) begin
                n_errors++;
                $display("FAIL %s: got %b want %b", e.name, intr_stat[1], e.exp[0]);
            end
            e = sb_q.pop_front();
            n_checks++;
            if (cnt(1) !== e.exp[WIDTH-1:0]) begin
                n_errors++;
                $display("FAIL %s: got %0d want %0d", e.name, cnt(1), e.exp);
            end
            intr_clr[1] = (k % 6 == 0);
        end
        intr_clr[1] = 1'b0;
        cfg_enb     = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_clr_collision();
        test_enb_freeze();
        test_reset_midcount();
`ifdef TIMER_CHAIN_EN
        test_chain();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
